// File: rtl/seg7_display_ctrl_if.sv
// rtl/seg7_display_ctrl_if.sv - control and segment-output bundle for seg7_display_ctrl
//
// Signals (master = watch FSM side, slave = display block):
//   digits_in   [4*NUM_DIGITS-1:0]  packed BCD, digit i at [4i+3:4i]
//   load                            capture digits_in on this edge
//   blink_en                        enable blinking of masked digits
//   blink_mask  [NUM_DIGITS-1:0]    bit i = 1 -> digit i blinks
//   lamp_test                       force all segments lit
//   hex_out     [7*NUM_DIGITS-1:0]  field i at [7i+6:7i], bit0 = a .. bit6 = g
//   blink_phase                     0 = visible half, 1 = blanked half
interface seg7_display_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic                    blink_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lamp_test;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    blink_phase;

  modport master (
    output digits_in, load, blink_en, blink_mask, lamp_test,
    input  hex_out, blink_phase
  );

  modport slave (
    input  digits_in, load, blink_en, blink_mask, lamp_test,
    output hex_out, blink_phase
  );
endinterface

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - registered N-digit BCD to seven-segment driver with blink and lamp test
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    seg7_display_ctrl_if.slave (digits_in, load, blink_en, blink_mask,
//          lamp_test in; hex_out, blink_phase out)
// Parameters: NUM_DIGITS (1..8), BLINK_DIV (>=2 clk per blink half-period),
//             SEG_ACTIVE_LOW (1 = segment lit when bit is 0)
// Optional macro: LEAD_ZERO_BLANK_EN enables leading-zero suppression.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  seg7_display_ctrl_if.slave  bus
);

  localparam int           CW        = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [6:0]   POL       = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0]   SEG_BLANK = POL;
  localparam logic [6:0]   SEG_ALL   = ~POL;

  logic [4*NUM_DIGITS-1:0] digit_reg;
  logic [CW-1:0]           presc;
  logic                    phase;
  logic [7*NUM_DIGITS-1:0] hex_reg;
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic [NUM_DIGITS-1:0]   suppress;

  assign bus.hex_out     = hex_reg;
  assign bus.blink_phase = phase;

  // Active-high segment pattern, bit6..bit0 = g..a; non-BCD codes are dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

`ifdef LEAD_ZERO_BLANK_EN
  // Walk down from the most significant digit; suppression stays on until the
  // first nonzero digit. Digit 0 is never part of the walk.
  logic lead;
  always_comb begin
    suppress = '0;
    lead     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digit_reg[4*i +: 4] != 4'd0) lead = 1'b0;
      suppress[i] = lead;
    end
  end
`else
  always_comb begin
    suppress = '0;
  end
`endif

  // Per-field priority: lamp test, then blanking (suppression or blink), then decode.
  always_comb begin
    hex_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.lamp_test)
        hex_next[7*i +: 7] = SEG_ALL;
      else if (suppress[i] || (bus.blink_en && bus.blink_mask[i] && phase))
        hex_next[7*i +: 7] = SEG_BLANK;
      else
        hex_next[7*i +: 7] = decode(digit_reg[4*i +: 4]) ^ POL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_reg <= '0;
      presc     <= '0;
      phase     <= 1'b0;
      hex_reg   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      if (bus.load)
        digit_reg <= bus.digits_in;

      // Holding the prescaler and phase at zero while disabled makes every
      // blink session start in the visible half.
      if (bus.blink_en) begin
        if (presc == CNT_LAST) begin
          presc <= '0;
          phase <= ~phase;
        end else begin
          presc <= presc + CW'(1);
        end
      end else begin
        presc <= '0;
        phase <= 1'b0;
      end

      hex_reg <= hex_next;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - self-checking bench for seg7_display_ctrl (6 digits, BLINK_DIV=4, active-low)
module tb_seg7_display_ctrl;

  localparam int N   = 6;
  localparam int DIV = 4;

  // Active-high digit shapes; the model inverts them for the active-low board.
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg7_display_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_display_ctrl #(
    .NUM_DIGITS(N),
    .BLINK_DIV(DIV),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference state: digit values and number of consecutive enabled-blink edges.
  int         m_dig [N];
  int         m_run;
  logic [41:0] m_hex_exp;
  logic       m_phase_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] pack6(input logic [6:0] f5, f4, f3, f2, f1, f0);
    return {f5, f4, f3, f2, f1, f0};
  endfunction

  function automatic logic [6:0] seg_al(input int d);
    if (d > 9) return 7'h7F;
    return ~SEG_TAB[d];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 0;
    m_run = 0;
    m_phase_exp = 1'b0;
  endtask

  // Expected output for the coming edge from pre-edge state, then advance state.
  task automatic model_step();
    int         top;
    logic       ph;
    logic [6:0] f;
    ph  = ((m_run / DIV) % 2) != 0;
    top = 0;
    for (int i = 0; i < N; i++) if (m_dig[i] != 0) top = i;
    for (int i = 0; i < N; i++) begin
      if (bus.lamp_test) f = 7'h00;
`ifdef LEAD_ZERO_BLANK_EN
      else if (i > top) f = 7'h7F;
`endif
      else if (bus.blink_en && bus.blink_mask[i] && ph) f = 7'h7F;
      else f = seg_al(m_dig[i]);
      m_hex_exp[7*i +: 7] = f;
    end
    if (bus.load)
      for (int i = 0; i < N; i++) m_dig[i] = int'(bus.digits_in[4*i +: 4]);
    m_run = bus.blink_en ? m_run + 1 : 0;
    m_phase_exp = ((m_run / DIV) % 2) != 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("hex_out", 64'(bus.hex_out), 64'(m_hex_exp));
    check("blink_phase", 64'(bus.blink_phase), 64'(m_phase_exp));
  endtask

  typedef struct {
    logic [23:0] digits;
    logic        lamp;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [41:0] exp_v;
    logic [13:0] exp_hi;

    vecs[0] = '{24'h235959, 1'b0, pack6(7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10)};
    vecs[1] = '{24'h123456, 1'b0, pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)};
    vecs[2] = '{24'h987A10, 1'b0, pack6(7'h10, 7'h00, 7'h78, 7'h7F, 7'h79, 7'h40)};
    vecs[3] = '{24'hFEDCBA, 1'b0, pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F)};
    vecs[4] = '{24'h808080, 1'b1, pack6(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00)};
    vecs[5] = '{24'h600600, 1'b0, pack6(7'h02, 7'h40, 7'h40, 7'h02, 7'h40, 7'h40)};

    reset          = 1'b0;
    bus.digits_in  = '0;
    bus.load       = 1'b0;
    bus.blink_en   = 1'b0;
    bus.blink_mask = '0;
    bus.lamp_test  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_hex", 64'(bus.hex_out), 64'(pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F)));
    check("reset_phase", 64'(bus.blink_phase), 64'd0);
    reset = 1'b1;

    // Release with no load: zeros decode on the first edge.
    tick();
`ifdef LEAD_ZERO_BLANK_EN
    exp_v = pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
    exp_v = pack6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
`endif
    check("release_zero", 64'(bus.hex_out), 64'(exp_v));

    // Table: load, then one more edge for the output register.
    for (int v = 0; v < 6; v++) begin
      bus.digits_in = vecs[v].digits;
      bus.lamp_test = vecs[v].lamp;
      bus.load      = 1'b1;
      tick();
      bus.load      = 1'b0;
      tick();
      check($sformatf("vec%0d", v), 64'(bus.hex_out), 64'(vecs[v].exp));
    end
    bus.lamp_test = 1'b0;

    // Load 23:59:59, then change digits_in with load low: display holds.
    bus.digits_in = 24'h235959;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
    bus.digits_in = 24'h111111;
    tick();
    tick();
    check("hold", 64'(bus.hex_out), 64'(vecs[0].exp));

    // Blink hours: phase toggles every DIV edges, lower fields steady.
    bus.blink_en   = 1'b1;
    bus.blink_mask = 6'b110000;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check("phase_seq", 64'(bus.blink_phase), 64'((n / DIV) % 2));
      exp_hi = (((n - 1) / DIV) % 2 != 0) ? {7'h7F, 7'h7F} : {7'h24, 7'h30};
      check("blink_hi", 64'(bus.hex_out[41:28]), 64'(exp_hi));
      check("blink_lo", 64'(bus.hex_out[27:0]), 64'({7'h12, 7'h10, 7'h12, 7'h10}));
    end
    // Now in the blanked half: lamp test wins.
    bus.lamp_test = 1'b1;
    tick();
    check("lamp_over_blink", 64'(bus.hex_out), 64'd0);
    bus.lamp_test = 1'b0;
    bus.blink_en  = 1'b0;
    tick();
    check("blink_off_hex", 64'(bus.hex_out), 64'(vecs[0].exp));
    check("blink_off_phase", 64'(bus.blink_phase), 64'd0);

    // Async reset in the blanked half of a blink.
    bus.blink_en   = 1'b1;
    bus.blink_mask = 6'b111111;
    for (int n = 0; n < 5; n++) tick();
    check("pre_reset_phase", 64'(bus.blink_phase), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_hex", 64'(bus.hex_out), 64'(pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F)));
    check("async_reset_phase", 64'(bus.blink_phase), 64'd0);
    model_reset();
    reset = 1'b1;
    bus.blink_en = 1'b0;
    tick();
    check("post_reset", 64'(bus.hex_out), 64'(exp_v));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++)
        bus.digits_in[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'(($urandom_range(0, 15))) :
                                  (($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9)));
      bus.load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) bus.blink_en = ~bus.blink_en;
      if ($urandom_range(0, 7) == 0) bus.blink_mask = 6'($urandom_range(0, 63));
      bus.lamp_test = ($urandom_range(0, 15) == 0);
      tick();
    end

`ifdef LEAD_ZERO_BLANK_EN
    bus.lamp_test = 1'b0;
    bus.blink_en  = 1'b0;
    bus.digits_in = 24'h000705;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
    tick();
    check("lzb_0705", 64'(bus.hex_out), 64'(pack6(7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h12)));
    bus.digits_in = 24'h000000;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
    tick();
    check("lzb_zero", 64'(bus.hex_out), 64'(pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
